// File: rtl/tlp_assembler.sv
// tlp_assembler: merges MWr (AW header + payload) and MRd (AR header) requests
// into one registered TLP beat stream, with round-robin arbitration.
//
// Optional feature macro: TLP_ASM_STAT_EN (adds per-type completed-TLP counters).
//
// Ports:
//   clk, rst                        core clock, async active-high reset
//   aw_fifo_empty/rdata/rden        MWr header FIFO (FWFT), rden is combinational
//   ar_fifo_empty/rdata/rden        MRd header FIFO (FWFT), rden is combinational
//   pw_fifo_empty/rdata/rden        payload FIFO, rdata = {last, data}
//   tlp_valid_o/ready_i             output handshake
//   tlp_data_o/sop_o/eop_o          output beat
//   err_o                           sticky: MWr payload exceeded MAX_PAYLOAD_BEATS
//   mwr_cnt_o/mrd_cnt_o             (TLP_ASM_STAT_EN only) accepted TLP counters
module tlp_assembler #(
    parameter int unsigned DATA_WIDTH        = 256,
    parameter int unsigned HDR_WIDTH         = 128,
    parameter int unsigned MAX_PAYLOAD_BEATS = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  aw_fifo_empty,
    input  logic [HDR_WIDTH-1:0]  aw_fifo_rdata,
    output logic                  aw_fifo_rden,
    input  logic                  ar_fifo_empty,
    input  logic [HDR_WIDTH-1:0]  ar_fifo_rdata,
    output logic                  ar_fifo_rden,
    input  logic                  pw_fifo_empty,
    input  logic [DATA_WIDTH:0]   pw_fifo_rdata,
    output logic                  pw_fifo_rden,
    output logic                  tlp_valid_o,
    input  logic                  tlp_ready_i,
    output logic [DATA_WIDTH-1:0] tlp_data_o,
    output logic                  tlp_sop_o,
    output logic                  tlp_eop_o,
    output logic                  err_o
`ifdef TLP_ASM_STAT_EN
    ,
    output logic [15:0]           mwr_cnt_o,
    output logic [15:0]           mrd_cnt_o
`endif
);

    localparam int unsigned CNT_W = $clog2(MAX_PAYLOAD_BEATS + 1);

    typedef enum logic {
        IDLE    = 1'b0,
        PAYLOAD = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    last_mwr_q, last_mwr_d;   // last grant went to MWr
    logic                    valid_d, sop_d, eop_d, err_d;
    logic [DATA_WIDTH-1:0]   data_d;
    logic                    aw_pop, ar_pop, pw_pop;
    logic                    slot_free, mwr_elig, mrd_elig, grant_mwr, grant_mrd;
    logic [CNT_W-1:0]        cnt_inc;

    assign slot_free = !tlp_valid_o || tlp_ready_i;
    assign mwr_elig  = !aw_fifo_empty && !pw_fifo_empty;
    assign mrd_elig  = !ar_fifo_empty;
    // Both eligible: serve the side opposite the last grant.
    assign grant_mwr = mwr_elig && (!mrd_elig || !last_mwr_q);
    assign grant_mrd = mrd_elig && !grant_mwr;
    assign cnt_inc   = cnt_q + CNT_W'(1);

    // Pops are suppressed while reset is held so FIFO contents survive reset.
    assign aw_fifo_rden = aw_pop && !rst;
    assign ar_fifo_rden = ar_pop && !rst;
    assign pw_fifo_rden = pw_pop && !rst;

    // Next-state, output-slot load and FIFO pop decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_mwr_d = last_mwr_q;
        valid_d    = tlp_valid_o;
        data_d     = tlp_data_o;
        sop_d      = tlp_sop_o;
        eop_d      = tlp_eop_o;
        err_d      = err_o;
        aw_pop     = 1'b0;
        ar_pop     = 1'b0;
        pw_pop     = 1'b0;

        if (slot_free) begin
            valid_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_mwr) begin
                        valid_d    = 1'b1;
                        data_d     = DATA_WIDTH'(aw_fifo_rdata);
                        sop_d      = 1'b1;
                        eop_d      = 1'b0;
                        aw_pop     = 1'b1;
                        cnt_d      = '0;
                        last_mwr_d = 1'b1;
                        state_d    = PAYLOAD;
                    end else if (grant_mrd) begin
                        valid_d    = 1'b1;
                        data_d     = DATA_WIDTH'(ar_fifo_rdata);
                        sop_d      = 1'b1;
                        eop_d      = 1'b1;
                        ar_pop     = 1'b1;
                        last_mwr_d = 1'b0;
                    end
                end
                PAYLOAD: begin
                    // Empty payload FIFO leaves a bubble; MRd never interleaves here.
                    if (!pw_fifo_empty) begin
                        valid_d = 1'b1;
                        data_d  = pw_fifo_rdata[DATA_WIDTH-1:0];
                        sop_d   = 1'b0;
                        pw_pop  = 1'b1;
                        cnt_d   = cnt_inc;
                        if (pw_fifo_rdata[DATA_WIDTH]) begin
                            eop_d   = 1'b1;
                            state_d = IDLE;
                        end else if (cnt_inc == CNT_W'(MAX_PAYLOAD_BEATS)) begin
                            // Oversized MWr: cut it here, leftover beats start the next MWr.
                            eop_d   = 1'b1;
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end else begin
                            eop_d   = 1'b0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_mwr_q  <= 1'b0;
            tlp_valid_o <= 1'b0;
            tlp_data_o  <= '0;
            tlp_sop_o   <= 1'b0;
            tlp_eop_o   <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_mwr_q  <= last_mwr_d;
            tlp_valid_o <= valid_d;
            tlp_data_o  <= data_d;
            tlp_sop_o   <= sop_d;
            tlp_eop_o   <= eop_d;
            err_o       <= err_d;
        end
    end

`ifdef TLP_ASM_STAT_EN
    // An eop beat with sop set is an MRd; MWr eop beats never carry sop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mwr_cnt_o <= '0;
            mrd_cnt_o <= '0;
        end else if (tlp_valid_o && tlp_ready_i && tlp_eop_o) begin
            if (tlp_sop_o) begin
                mrd_cnt_o <= mrd_cnt_o + 16'd1;
            end else begin
                mwr_cnt_o <= mwr_cnt_o + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/tlp_assembler.md
Name: tlp_assembler

Overview:
- Downstream stage of the AW/AR header FIFOs and the write-payload FIFO in the PCIe top wrapper.
- Pops 128-bit headers and payload beats and emits a single TLP beat stream toward the link layer.
- MRd TLPs carry a header only. MWr TLPs carry a header plus payload beats, up to and including the beat flagged last.
- Round-robin arbitration between MWr and MRd, with one registered output slot and valid/ready backpressure.

Parameters:
- DATA_WIDTH, 256, TLP beat width and payload FIFO data width; must be ≥ 128.
- HDR_WIDTH, 128, header FIFO entry width (4DW header).
- MAX_PAYLOAD_BEATS, 16, maximum payload beats per MWr before forced termination.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- aw_fifo_empty  in  1  MWr header FIFO empty
- aw_fifo_rdata  in  HDR_WIDTH  MWr header at FIFO head (first-word fall-through)
- aw_fifo_rden  out  1  pop MWr header
- ar_fifo_empty  in  1  MRd header FIFO empty
- ar_fifo_rdata  in  HDR_WIDTH  MRd header at FIFO head
- ar_fifo_rden  out  1  pop MRd header
- pw_fifo_empty  in  1  payload FIFO empty
- pw_fifo_rdata  in  DATA_WIDTH+1  payload head; bit [DATA_WIDTH] = last, bits [DATA_WIDTH-1:0] = data
- pw_fifo_rden  out  1  pop payload beat
- tlp_valid_o  out  1  output beat valid
- tlp_ready_i  in  1  downstream accepts beat
- tlp_data_o  out  DATA_WIDTH  beat data
- tlp_sop_o  out  1  first beat of TLP
- tlp_eop_o  out  1  last beat of TLP
- err_o  out  1  sticky: payload exceeded MAX_PAYLOAD_BEATS

Behaviour:
- Reset (async, rst=1):
  - All outputs are 0; state = IDLE; beat counter = 0.
  - Round-robin pointer set so MWr has priority first.
  - Reset mid-TLP abandons the TLP with no eop. FIFO contents are not touched.
- FIFO reads:
  - All FIFOs are FWFT: rdata is valid whenever empty=0; rden=1 pops at the clock edge.
  - rden is combinational and is never asserted while the corresponding empty=1.
- Output slot:
  - slot_free = !tlp_valid_o || tlp_ready_i.
  - A beat is loaded, and its source popped, only in a cycle where slot_free=1.
  - tlp_data/sop/eop remain stable while tlp_valid_o=1 && tlp_ready_i=0.
- Eligibility:
  - MWr is eligible when !aw_fifo_empty && !pw_fifo_empty.
  - MRd is eligible when !ar_fifo_empty.
- State IDLE, when slot_free:
  - If both are eligible, grant the one opposite the last grant; otherwise grant the single eligible one.
  - Grant MRd: load {zero-pad, ar_fifo_rdata} into tlp_data_o[127:0] with sop=1, eop=1; pop AR; stay in IDLE. Back-to-back MRd sustains 1 TLP/cycle.
  - Grant MWr: load the AW header with sop=1, eop=0; pop AW; counter = 0; go to PAYLOAD.
  - No grant: tlp_valid_o drops to 0 once the current beat is accepted.
- State PAYLOAD, when slot_free && !pw_fifo_empty:
  - Load a payload beat with sop=0, eop=last; pop PW; counter += 1.
  - If last=1: go to IDLE, record the grant as MWr.
  - If counter reaches MAX_PAYLOAD_BEATS with last=0: force eop=1, set err_o, go to IDLE. Remaining beats belong to the next MWr.
- Payload FIFO empty mid-TLP: insert bubbles (tlp_valid_o=0). The TLP is never interleaved with an MRd.
- Latency: FIFO head to tlp_valid_o is 1 cycle (registered output).
- Counter width: clog2(MAX_PAYLOAD_BEATS+1).

Optional Feature:
- Macro TLP_ASM_STAT_EN.
- Defined:
  - Adds 16-bit outputs mwr_cnt_o and mrd_cnt_o, reset to 0.
  - Each increments by 1, wrapping at 0xFFFF→0, when a beat with eop=1 of that type is accepted (valid && ready).
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset with FIFOs non-empty, rst held 3 cycles → all outputs 0, no rden pulses; first beat appears 1 cycle after rst deasserts.
- AR holds 1 header 0xA5..A5, ready=1 → one beat, data[127:0]=header, upper bits 0, sop=eop=1; ar_fifo_rden pulses once.
- AW header H plus payload beats D0 (last=0), D1 (last=1), ready=1 → 3 consecutive beats H(sop), D0, D1(eop); aw_fifo_rden 1 pulse, pw_fifo_rden 2 pulses.
- 2 MWr (1 payload beat each) and 2 MRd all pending → TLP order MWr, MRd, MWr, MRd.
- tlp_ready_i low for 4 cycles during an MWr payload → beat held stable, no pops; then resumes with no beat lost or duplicated.
- 17 payload beats with no last, MAX_PAYLOAD_BEATS=16 → eop on the 16th payload beat, err_o=1 and sticky until reset; TLP_ASM_STAT_EN build shows mwr_cnt_o=1.
